// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Latency from the start-sampling edge to the done pulse is BIN_W+1 cycles.
// Build option: define BCD_LEADING_BLANK_EN to replace leading zero digits
// (never digit 0) with 4'hF so downstream seven-segment decoders show blank.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  sr_q, sr_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [BcdW-1:0]   scratch_adj;
  logic [BcdW-1:0]   bcd_fmt;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
`ifdef BCD_LEADING_BLANK_EN
  logic              lead;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; counter reaching 1 marks the final shift
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StShift;
      StShift:  if (cnt_q == CntW'(1)) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Add-3 correction applied to every scratch digit >= 5 before each shift
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  // Datapath next-state: load on accepted start, shift one bit per SHIFT cycle
  always_comb begin
    sr_d      = sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d      = bin_in;
          scratch_d = '0;
          cnt_d     = CntW'(BIN_W);
        end
      end
      StShift: begin
        {scratch_d, sr_d} = {scratch_adj, sr_q} << 1;
        cnt_d             = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
    end else begin
      sr_q      <= sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
    end
  end

  // Output formatting of the finished scratch (optional leading-zero blanking)
  always_comb begin
    bcd_fmt = scratch_q;
`ifdef BCD_LEADING_BLANK_EN
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (scratch_q[4*i +: 4] == 4'd0)) bcd_fmt[4*i +: 4] = 4'hF;
      else                                       lead = 1'b0;
    end
`endif
  end

  // Output next-state: busy follows the next state, done/bcd update leaving FINISH
  always_comb begin
    busy_d = (state_d != StIdle);
    done_d = (state_q == StFinish);
    bcd_d  = bcd_q;
    if (state_q == StFinish) bcd_d = bcd_fmt;
  end

  // Output registers; no combinational path from inputs to outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q  <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (default parameters, both macro builds).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;

  int passed = 0;
  int total  = 0;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [19:0] Exp0    = 20'hFFFF0;
  localparam logic [19:0] Exp1234 = 20'hF1234;
  localparam logic [19:0] Exp42   = 20'hFFF42;
  localparam logic [19:0] Exp9    = 20'hFFFF9;
  localparam logic [19:0] Exp305  = 20'hFF305;
`else
  localparam logic [19:0] Exp0    = 20'h00000;
  localparam logic [19:0] Exp1234 = 20'h01234;
  localparam logic [19:0] Exp42   = 20'h00042;
  localparam logic [19:0] Exp9    = 20'h00009;
  localparam logic [19:0] Exp305  = 20'h00305;
`endif
  localparam logic [19:0] Exp65535 = 20'h65535;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one conversion; returns on the cycle done is seen (or after 40 cycles)
  task automatic run(input logic [15:0] val, output int lat, output int bcnt);
    start  = 1'b1;
    bin_in = val;
    step();
    start  = 1'b0;
    bin_in = 16'($urandom);
    lat    = -1;
    bcnt   = 0;
    if (busy) bcnt++;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;

    // Reset with start also high: reset must win
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 16'd7;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd_out), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    step();

    run(16'd0, lat, bcnt);
    check("zero_latency", lat, 17);
    check("zero_busy_cycles", bcnt, 17);
    check("zero_bcd", 32'(bcd_out), 32'(Exp0));
    step();
    check("zero_done_one_cycle", 32'(done), 32'd0);
    step();

    run(16'd65535, lat, bcnt);
    check("max_latency", lat, 17);
    check("max_busy_cycles", bcnt, 17);
    check("max_bcd", 32'(bcd_out), 32'(Exp65535));

    // Start during the done cycle is accepted
    run(16'd9, lat, bcnt);
    check("b2b_latency", lat, 17);
    check("b2b_bcd", 32'(bcd_out), 32'(Exp9));
    step();
    check("b2b_done_drop", 32'(done), 32'd0);
    step();

    run(16'd1234, lat, bcnt);
    check("v1234_latency", lat, 17);
    check("v1234_bcd", 32'(bcd_out), 32'(Exp1234));
    step();

    // Second start at cycle 5 must be ignored
    start  = 1'b1;
    bin_in = 16'd42;
    step();
    start  = 1'b0;
    bin_in = 16'd0;
    dcnt   = 0;
    lat    = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        start  = 1'b1;
        bin_in = 16'd999;
      end else begin
        start  = 1'b0;
      end
      step();
      if (done) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
    end
    start = 1'b0;
    check("ignore_done_count", dcnt, 1);
    check("ignore_latency", lat, 17);
    check("ignore_bcd", 32'(bcd_out), 32'(Exp42));

    // Reset at cycle 8 of a conversion aborts it
    start  = 1'b1;
    bin_in = 16'd65535;
    step();
    start  = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    dcnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) dcnt++;
      step();
    end
    check("abort_no_done", dcnt, 0);
    check("abort_bcd", 32'(bcd_out), 32'd0);

    run(16'd305, lat, bcnt);
    check("after_abort_latency", lat, 17);
    check("after_abort_bcd", 32'(bcd_out), 32'(Exp305));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
